fifo_stream_drain: RTL and testbench

//   Downstream consumer of the synchronous FIFO. Pops words through the FIFO read port,

---
 rtl/fifo_stream_drain.sv | 117 +++++++++++
 tb/tb_fifo_stream_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
// Pops a registered-read FIFO into a 2-entry buffer and emits a valid/ready stream with TLAST every PKT_LEN beats.
// First beat 2 cycles after the first read; reads throttle so buffered + in-flight words never exceed 2 under back-pressure.
module fifo_stream_drain #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4,
    parameter int PCNT_W  = 16
) (
    input  logic              I_CLK,
    input  logic              I_RESET,
    input  logic              I_EN,
    output logic              O_FIFO_RE,
    input  logic [WIDTH-1:0]  I_FIFO_DOUT,
    input  logic              I_FIFO_EMPTY,
    output logic [WIDTH-1:0]  O_TDATA,
    output logic              O_TVALID,
    output logic              O_TLAST,
    input  logic              I_TREADY,
    output logic [PCNT_W-1:0] O_PKT_CNT,
    output logic              O_BUSY
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_buf0;
    logic [WIDTH-1:0]  r_buf1;
    logic [1:0]        r_buf_cnt;
    logic              r_inflight;
    logic [7:0]        r_beat_cnt;
    logic [PCNT_W-1:0] r_pkt_cnt;

    logic              w_pop;
    logic              w_held;
    logic [2:0]        w_occ_nxt;
    logic [1:0]        w_push_idx;

    assign O_TVALID  = (r_buf_cnt != 2'd0);
    assign O_TDATA   = r_buf0;
    assign O_TLAST   = O_TVALID && (r_beat_cnt == LAST_BEAT);
    assign O_PKT_CNT = r_pkt_cnt;
    assign O_BUSY    = (r_state != ST_IDLE);

    assign w_pop      = O_TVALID & I_TREADY;
    assign w_held     = (r_buf_cnt != 2'd0) || r_inflight;
    // Occupancy after this edge; a new read is only safe if it leaves room for its word.
    assign w_occ_nxt  = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign O_FIFO_RE  = !I_RESET && I_EN && !I_FIFO_EMPTY && (w_occ_nxt < 3'd2);
    assign w_push_idx = r_buf_cnt - {1'b0, w_pop};

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_buf_cnt  <= 2'd0;
            r_inflight <= 1'b0;
            r_beat_cnt <= 8'd0;
            r_pkt_cnt  <= '0;
        end else begin
            assert (w_occ_nxt <= 3'd2);
            r_inflight <= O_FIFO_RE;
            r_buf_cnt  <= w_occ_nxt[1:0];
            if (w_pop) begin
                r_buf0 <= r_buf1;
            end
            if (r_inflight) begin
                if (w_push_idx == 2'd0) begin
                    r_buf0 <= I_FIFO_DOUT;
                end else begin
                    r_buf1 <= I_FIFO_DOUT;
                end
            end
            if (w_pop) begin
                r_beat_cnt <= O_TLAST ? 8'd0 : r_beat_cnt + 8'd1;
                if (O_TLAST) begin
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (I_EN && !I_FIFO_EMPTY) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!I_EN) begin
                    w_state_nxt = w_held ? ST_DRAIN : ST_IDLE;
                end else if (I_FIFO_EMPTY && !w_held) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (I_EN) begin
                    w_state_nxt = ST_RUN;
                end else if (!w_held) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench: a 10-deep registered-read FIFO model feeds the drain; a scoreboard checks order, TLAST, packet count and stall stability.
module tb_fifo_stream_drain;
    localparam int W     = 8;
    localparam int PL    = 4;
    localparam int PCW   = 16;
    localparam int DEPTH = 10;

    logic           clk = 1'b0;
    logic           d_rst, f_rst, en, tready, wr_en;
    logic [W-1:0]   wr_dat;
    logic           re, fempty, tvalid, tlast, busy;
    logic [W-1:0]   fdout, tdata;
    logic [PCW-1:0] pkt;

    always #5 clk = ~clk;

    fifo_stream_drain #(.WIDTH(W), .PKT_LEN(PL), .PCNT_W(PCW)) dut (
        .I_CLK(clk), .I_RESET(d_rst), .I_EN(en), .O_FIFO_RE(re),
        .I_FIFO_DOUT(fdout), .I_FIFO_EMPTY(fempty),
        .O_TDATA(tdata), .O_TVALID(tvalid), .O_TLAST(tlast), .I_TREADY(tready),
        .O_PKT_CNT(pkt), .O_BUSY(busy)
    );

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] wr_log [$];
    int wp = 0, rp = 0, fcnt = 0, rd_total = 0;

    assign fempty = (fcnt == 0);

    always @(posedge clk) begin
        if (f_rst) begin
            wp <= 0; rp <= 0; fcnt <= 0; fdout <= '0;
        end else begin
            if (wr_en && fcnt < DEPTH) begin
                mem[wp] <= wr_dat;
                wp <= (wp + 1) % DEPTH;
                wr_log.push_back(wr_dat);
            end
            if (re && fcnt > 0) begin
                fdout <= mem[rp];
                rp <= (rp + 1) % DEPTH;
                rd_total <= rd_total + 1;
            end
            fcnt <= fcnt + ((wr_en && fcnt < DEPTH) ? 1 : 0) - ((re && fcnt > 0) ? 1 : 0);
        end
    end

    int n_cmp = 0, n_fail = 0;
    int exp_idx = 0, pop_total = 0, beats = 0;
    bit hold_pend = 0;
    logic [W-1:0] hold_dat;
    logic hold_last;

    typedef struct {
        bit en; bit rdy; bit re; bit vld; logic [7:0] dat; bit last; int pkt; bit busy;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            tick(); wr_en = 1'b1; wr_dat = base + 8'(i);
        end
        tick(); wr_en = 1'b0;
    endtask

    task automatic reset_dut(input bit with_fifo);
        tick(); d_rst = 1'b1; f_rst = with_fifo;
        tick();
        check("rst_vld", tvalid, 0);
        check("rst_last", tlast, 0);
        check("rst_dat", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt", pkt, 0);
        check("rst_re", re, 0);
        d_rst = 1'b0; f_rst = 1'b0;
    endtask

    task automatic wait_drain(input int bound, input bit rnd);
        bit done = 0;
        for (int c = 0; c < bound && !done; c++) begin
            tick();
            if (rnd) tready = 1'($urandom % 2);
            done = (fcnt == 0) && (exp_idx == wr_log.size()) && !tvalid;
        end
        check("drain_done", done, 1);
    endtask

    initial begin
        int rd0, rp0, sent;
        d_rst = 1'b1; f_rst = 1'b1; en = 1'b0; tready = 1'b0; wr_en = 1'b0; wr_dat = '0;

        fork
            forever begin
                @(negedge clk);
                if (d_rst || f_rst) begin
                    // Reset discards whatever the drain had read but not yet delivered.
                    if (f_rst) exp_idx = wr_log.size();
                    else exp_idx += rd_total - pop_total;
                    pop_total = rd_total; beats = 0; hold_pend = 0;
                end else begin
                    check("fifo_underflow", re && fempty, 0);
                    check("pkt_cnt", pkt, (beats / PL) % (1 << PCW));
                    if (hold_pend) begin
                        check("hold_vld", tvalid, 1);
                        check("hold_dat", tdata, hold_dat);
                        check("hold_last", tlast, hold_last);
                    end
                    hold_pend = tvalid && !tready; hold_dat = tdata; hold_last = tlast;
                    if (tvalid && tready) begin
                        if (exp_idx >= wr_log.size()) begin
                            n_cmp++; n_fail++;
                            $display("FAIL beat_extra: got beat 0x%0h, expected no beat", tdata);
                        end else begin
                            check("beat_dat", tdata, wr_log[exp_idx]);
                        end
                        check("beat_last", tlast, (beats % PL) == PL - 1);
                        exp_idx++; pop_total++; beats++;
                    end
                end
            end
        join_none

        reset_dut(1);

        // Test 1: eight words back-to-back, cycle-exact.
        tbl[0]  = '{1, 1, 1, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 8'h00, 0, 0, 1};
        tbl[2]  = '{1, 1, 1, 1, 8'h01, 0, 0, 1};
        tbl[3]  = '{1, 1, 1, 1, 8'h02, 0, 0, 1};
        tbl[4]  = '{1, 1, 1, 1, 8'h03, 0, 0, 1};
        tbl[5]  = '{1, 1, 1, 1, 8'h04, 1, 0, 1};
        tbl[6]  = '{1, 1, 1, 1, 8'h05, 0, 1, 1};
        tbl[7]  = '{1, 1, 1, 1, 8'h06, 0, 1, 1};
        tbl[8]  = '{1, 1, 0, 1, 8'h07, 0, 1, 1};
        tbl[9]  = '{1, 1, 0, 1, 8'h08, 1, 1, 1};
        tbl[10] = '{1, 1, 0, 0, 8'h00, 0, 2, 1};
        tbl[11] = '{1, 1, 0, 0, 8'h00, 0, 2, 0};
        push_words(8, 8'h01);
        for (int i = 0; i < 12; i++) begin
            tick(); en = tbl[i].en; tready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("t1_re[%0d]", i), re, tbl[i].re);
            check($sformatf("t1_vld[%0d]", i), tvalid, tbl[i].vld);
            check($sformatf("t1_last[%0d]", i), tlast, tbl[i].last);
            check($sformatf("t1_pkt[%0d]", i), pkt, tbl[i].pkt);
            check($sformatf("t1_busy[%0d]", i), busy, tbl[i].busy);
            if (tbl[i].vld) check($sformatf("t1_dat[%0d]", i), tdata, tbl[i].dat);
        end
        check("t1_fifo_empty", fempty, 1);

        // Test 2: full FIFO under back-pressure.
        en = 1'b0; tready = 1'b0;
        push_words(10, 8'h10);
        en = 1'b1; rd0 = rd_total;
        repeat (20) tick();
        check("t2_reads", rd_total - rd0, 2);
        check("t2_fcnt", fcnt, 8);
        check("t2_vld", tvalid, 1);
        check("t2_dat", tdata, 8'h10);
        tready = 1'b1;
        wait_drain(100, 0);
        check("t2_total_reads", rd_total - rd0, 10);
        check("t2_beats", beats, 18);

        // Test 3: empty FIFO never read.
        rp0 = rp;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("t3_re", re, 0);
            check("t3_vld", tvalid, 0);
        end
        check("t3_rp", rp, rp0);

        // Test 4: stall mid-packet, resume at the same beat.
        reset_dut(1);
        en = 1'b1; tready = 1'b1;
        push_words(3, 8'h41);
        repeat (8) tick();
        check("t4_beats", beats, 3);
        check("t4_stall_vld", tvalid, 0);
        check("t4_stall_pkt", pkt, 0);
        check("t4_stall_busy", busy, 0);
        push_words(1, 8'hAA);
        for (int c = 0; c < 10 && !tvalid; c++) tick();
        check("t4_dat", tdata, 8'hAA);
        check("t4_last", tlast, 1);
        tick();
        check("t4_pkt", pkt, 1);

        // Test 5: random back-pressure, writer as fast as the FIFO allows.
        reset_dut(1);
        en = 1'b1; sent = 0;
        for (int c = 0; c < 3000 && sent < 200; c++) begin
            tick();
            tready = 1'($urandom % 2);
            if (fcnt < DEPTH) begin
                wr_en = 1'b1; wr_dat = 8'($urandom); sent++;
            end else begin
                wr_en = 1'b0;
            end
        end
        tick(); wr_en = 1'b0;
        check("t5_sent", sent, 200);
        wait_drain(2000, 1);
        check("t5_beats", beats, 200);
        check("t5_pkt", pkt, 50);

        // Test 6: drop enable with two words buffered, then reset mid-packet.
        reset_dut(1);
        en = 1'b1; tready = 1'b0;
        push_words(3, 8'h61);
        repeat (6) tick();
        check("t6_vld", tvalid, 1);
        check("t6_fcnt", fcnt, 1);
        rd0 = rd_total; en = 1'b0;
        tick();
        check("t6_drain_busy", busy, 1);
        repeat (5) tick();
        tready = 1'b1;
        repeat (4) tick();
        check("t6_drain_beats", beats, 2);
        check("t6_idle", busy, 0);
        check("t6_no_reads", rd_total - rd0, 0);
        check("t6_fcnt_left", fcnt, 1);
        tready = 1'b0; en = 1'b1;
        push_words(5, 8'h71);
        repeat (4) tick();
        tready = 1'b1;
        repeat (3) tick();
        tready = 1'b0;
        repeat (3) tick();
        check("t6_pre_beats", beats, 5);
        check("t6_pre_pkt", pkt, 1);
        check("t6_pre_vld", tvalid, 1);
        reset_dut(0);
        tready = 1'b1;
        push_words(4, 8'h81);
        wait_drain(60, 0);
        check("t6_post_beats", beats, 5);
        check("t6_post_pkt", pkt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
